clk_div_prog: RTL
=================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the divide-ratio input and period counter (valid range 2..16).
REQ-002 SHALL have parameter DEFAULT_DIV, default 10: divide ratio active after reset (legal range 2..2^CNT_W-1).
REQ-003 SHALL have port CLKIN  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port CDRST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port EN  input  1  run request: 1 = generate output clock, 0 = finish current period then park low.
REQ-006 SHALL have port LOAD  input  1  single-cycle strobe that captures DIV as the pending ratio.
REQ-007 SHALL have port DIV  input  CNT_W  requested divide ratio N, sampled only when LOAD=1.
REQ-008 SHALL have port CLKDV  output  1  registered divided clock.
REQ-009 SHALL have port TICK  output  1  one-cycle pulse coincident with each CLKDV rising edge.
REQ-010 SHALL have port BUSY  output  1  high in RUN and DRAIN states.
REQ-011 SHALL have port ACK  output  1  one-cycle pulse when a pending ratio becomes active.

Function
REQ-012 SHALL implement states IDLE, RUN and DRAIN; period counter CNT counts 0..N-1 and wraps to 0.
REQ-013 SHALL clamp any captured DIV value of 0 or 1 to 2.
REQ-014 SHALL drive CLKDV=1 for the H=ceil(N/2) cycles CNT=0..H-1 and CLKDV=0 for the N-H cycles CNT=H..N-1 (even N: 50%; odd N: one extra high cycle).
REQ-015 SHALL transition IDLE->RUN on the first edge with EN=1; on that edge CNT<=0, CLKDV<=1, TICK<=1, with the pending ratio activated first if one is present.
REQ-016 SHALL, in RUN with EN=0 sampled, enter DRAIN without altering CLKDV or CNT sequencing.
REQ-017 SHALL, in DRAIN with EN=1 sampled, return to RUN with no phase disturbance.
REQ-018 SHALL, at the period boundary (CNT=N-1) in DRAIN, enter IDLE with CLKDV=0 and CNT=0; no truncated high or low phase is ever emitted.
REQ-019 SHALL, at the period boundary in RUN, wrap CNT to 0, drive CLKDV<=1 and TICK<=1, and first activate the pending ratio if PEND=1.
REQ-020 SHALL, on LOAD=1, store the clamped DIV in the pending register and set PEND; a second LOAD before activation overwrites the pending value, and only one ACK is produced.
REQ-021 SHALL pulse ACK for exactly one cycle on the edge where the pending value becomes active, and clear PEND on that edge.
REQ-022 SHALL, in IDLE, activate a pending ratio on the edge after LOAD is sampled (ACK 1 cycle after LOAD).
REQ-023 SHALL, when LOAD coincides with a period boundary, finish the boundary using the previous pending or active ratio; the new value applies at the following boundary.
REQ-024 SHALL never change the active ratio mid-period: every high/low phase length derives from the single N active at the period start.
REQ-025 SHALL hold TICK=0 in IDLE and DRAIN-to-IDLE cycles; TICK is never asserted while EN is low at a boundary.

Reset
REQ-026 SHALL, while CDRST_N=0 regardless of CLKIN: CLKDV=0, TICK=0, BUSY=0, ACK=0, state=IDLE, CNT=0, active N=DEFAULT_DIV, PEND=0.
REQ-027 SHALL abort any period in progress on asserted reset (no drain) and begin sampling EN on the first rising edge after CDRST_N deasserts.

Verification
REQ-028 Reset then EN=1, default N=10 -> CLKDV 5 high/5 low repeating, TICK once per 10 cycles, BUSY=1.
REQ-029 LOAD DIV=7 mid-period of N=10 -> current period completes at 10, then 4 high/3 low; ACK exactly on the first N=7 rising edge.
REQ-030 EN dropped at CNT=2 of N=10 -> remaining 2 high + 5 low cycles emitted, then IDLE, BUSY=0, CLKDV stays 0, no TICK.
REQ-031 LOAD DIV=0 and DIV=1 in IDLE -> ACK after 1 cycle; running produces 1 high/1 low (N=2).
REQ-032 CDRST_N pulsed low between edges at CNT=3 -> all outputs 0 immediately; after release with EN=1, a fresh N=DEFAULT_DIV period starts.
REQ-033 LOAD on the boundary edge, then EN toggled 1->0->1 within one period -> no phase disturbance; new ratio and ACK arrive at the next boundary.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free start/stop and a
// double-buffered divide ratio that only takes effect on period boundaries.
module clk_div_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             CLKIN,
  input  logic             CDRST_N,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] DIV,
  output logic             CLKDV,
  output logic             TICK,
  output logic             BUSY,
  output logic             ACK
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] n_pend;
  logic             pend;

  logic [CNT_W-1:0] div_c;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_end;

  // Ratios below 2 cannot produce both a high and a low phase.
  assign div_c   = (DIV < CNT_W'(2)) ? CNT_W'(2) : DIV;
  assign half    = (n_act >> 1) + CNT_W'(n_act[0]);
  assign cnt_inc = cnt + CNT_W'(1);
  assign at_end  = (cnt == n_act - CNT_W'(1));

  always_ff @(posedge CLKIN or negedge CDRST_N) begin
    if (!CDRST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      n_act  <= CNT_W'(DEFAULT_DIV);
      n_pend <= CNT_W'(DEFAULT_DIV);
      pend   <= 1'b0;
      CLKDV  <= 1'b0;
      TICK   <= 1'b0;
      BUSY   <= 1'b0;
      ACK    <= 1'b0;
    end else begin
      TICK <= 1'b0;
      ACK  <= 1'b0;
      case (state)
        IDLE: begin
          if (pend) begin
            n_act <= n_pend;
            pend  <= 1'b0;
            ACK   <= 1'b1;
          end
          if (EN) begin
            state <= RUN;
            cnt   <= '0;
            CLKDV <= 1'b1;
            TICK  <= 1'b1;
            BUSY  <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (at_end) begin
            if (EN) begin
              // New period: the ratio swap happens only here, so a period
              // never mixes two ratios.
              state <= RUN;
              cnt   <= '0;
              CLKDV <= 1'b1;
              TICK  <= 1'b1;
              BUSY  <= 1'b1;
              if (pend) begin
                n_act <= n_pend;
                pend  <= 1'b0;
                ACK   <= 1'b1;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
              CLKDV <= 1'b0;
              BUSY  <= 1'b0;
            end
          end else begin
            state <= EN ? RUN : DRAIN;
            cnt   <= cnt_inc;
            CLKDV <= (cnt_inc < half);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          CLKDV <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
      // Placed last so a capture on an activation edge re-arms PEND with the new value.
      if (LOAD) begin
        n_pend <= div_c;
        pend   <= 1'b1;
      end
    end
  end

endmodule
